// File: rtl/led_period_meter_pkg.sv
// Shared constants and state encoding for the LED period meter.
package led_period_meter_pkg;

  localparam int CNT_W_DEF   = 26;
  localparam int TIMEOUT_DEF = 50_000_000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by an edge register; rise/fall are valid
// in the cycle the FSM samples them (third clock edge after the input moves).
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic level_q, level_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d  = d_in;
    level_d = meta_q;
    prev_d  = level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/led_period_meter.sv
// Measures rising-to-rising period and rising-to-falling high time of sig_in.
//   state      | meaning
//   ST_IDLE    | waiting for a first rising edge to arm the counter
//   ST_MEASURE | counting cycles since the last rising edge
module led_period_meter
  import led_period_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             level_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic rise_w, fall_w, level_w;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  sync_edge_detect u_sync (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .d_in  (sig_in),
    .level (level_w),
    .rise  (rise_w),
    .fall  (fall_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (rise_w) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // The falling-edge cycle still counts toward the period.
        cnt_d = cnt_inc;
        if (rise_w) begin
          period_d  = cnt_inc;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end else begin
          if (fall_w) high_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign level_out    = level_w;

endmodule

// File: tb/tb_led_period_meter.sv
// Self-checking bench: random and directed waveforms compared cycle by cycle
// against a timestamp-based reference model of the period meter.
module tb_led_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             sig_in  = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, timeout, level_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 sys_clk = ~sys_clk;

  led_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout),
    .level_out    (level_out)
  );

  // Reference model: every input change seen at clock n shows on level_out
  // after clock n+1 and is acted on as an edge at clock n+2.
  typedef struct {int t; logic v;} ev_t;
  ev_t lvl_q[$];
  ev_t edg_q[$];
  int  cyc, last_rise;
  bit  armed, m_lvl, m_rise, m_fall;
  logic [CNT_W-1:0] exp_period = '0, exp_high = '0;
  logic exp_valid = 1'b0, exp_timeout = 1'b0, exp_level = 1'b0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      cyc = 0; last_rise = 0; armed = 0; m_lvl = 0;
      exp_period = '0; exp_high = '0; exp_valid = 0; exp_timeout = 0; exp_level = 0;
      lvl_q.delete(); edg_q.delete();
    end else begin
      cyc++;
      exp_valid = 0;
      m_rise = 0;
      m_fall = 0;
      if (sig_in !== m_lvl) begin
        m_lvl = sig_in;
        lvl_q.push_back('{cyc + 1, sig_in});
        edg_q.push_back('{cyc + 2, sig_in});
      end
      if (lvl_q.size() > 0 && lvl_q[0].t == cyc) exp_level = lvl_q.pop_front().v;
      if (edg_q.size() > 0 && edg_q[0].t == cyc) begin
        if (edg_q[0].v) m_rise = 1; else m_fall = 1;
        void'(edg_q.pop_front());
      end
      if (m_rise) begin
        if (armed) begin
          exp_period  = CNT_W'(cyc - last_rise);
          exp_valid   = 1;
          exp_timeout = 0;
        end
        armed = 1;
        last_rise = cyc;
      end else if (armed) begin
        if (m_fall) exp_high = CNT_W'(cyc - last_rise);
        if (cyc - last_rise == TIMEOUT) begin
          exp_timeout = 1;
          armed = 0;
        end
      end
    end
  end

  logic wq[$];
  int   nv, first_v, first_t;
  logic [CNT_W-1:0] seen_p[$];

  function automatic string obs();
    return $sformatf("got p=%0d h=%0d v=%b t=%b l=%b want p=%0d h=%0d v=%b t=%b l=%b",
                     period, high_time, period_valid, timeout, level_out,
                     exp_period, exp_high, exp_valid, exp_timeout, exp_level);
  endfunction

  task automatic gen_wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < p; j++) wq.push_back(j < h);
  endtask

  task automatic gen_low(input int n);
    for (int j = 0; j < n; j++) wq.push_back(1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    sig_in  = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if ({period, high_time, period_valid, timeout, level_out} !== '0) begin
      n_fail++; $display("FAIL reset_state %s", obs());
    end
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if ({period_valid, timeout, level_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle %s", obs());
    end
  endtask

  task automatic test_square20();
    do_reset();
    gen_wave(20, 10, 3); gen_low(6);
    nv = 0; first_v = -1;
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL square20 i=%0d %s", i, obs());
      end
      if (period_valid) begin nv++; if (first_v < 0) first_v = i; end
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (first_v != 23) begin n_fail++; $display("FAIL square20_first_valid got %0d want 23", first_v); end
    n_checks++;
    if (nv != 2 || period !== 20 || high_time !== 10) begin
      n_fail++; $display("FAIL square20_final got nv=%0d p=%0d h=%0d want 2 20 10", nv, period, high_time);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wq.push_back(1'b1); wq.push_back(1'b1); wq.push_back(1'b1); wq.push_back(1'b1); wq.push_back(1'b1);
    gen_low(120);
    nv = 0; first_t = -1;
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL timeout i=%0d %s", i, obs());
      end
      if (period_valid) nv++;
      if (timeout && first_t < 0) first_t = i;
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (first_t != 103 || nv != 0 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_assert got at=%0d nv=%0d t=%b want 103 0 1", first_t, nv, timeout);
    end
    gen_wave(30, 15, 3); gen_low(6);
    nv = 0;
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL resume i=%0d %s", i, obs());
      end
      if (period_valid) nv++;
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (nv != 2 || period !== 30 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL resume_final got nv=%0d p=%0d t=%b want 2 30 0", nv, period, timeout);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    gen_wave(24, 12, 2); gen_wave(24, 12, 3); gen_low(6);
    nv = 0;
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL mid_reset i=%0d %s", i, obs());
      end
      if (period_valid) nv++;
      if (i == 30) begin
        sys_rst = 1'b1;
        #1;
        n_checks++;
        if ({period, high_time, period_valid, timeout, level_out} !== '0) begin
          n_fail++; $display("FAIL mid_reset_clear %s", obs());
        end
      end
      if (i == 32) sys_rst = 1'b0;
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (nv != 4 || period !== 24) begin
      n_fail++; $display("FAIL mid_reset_final got nv=%0d p=%0d want 4 24", nv, period);
    end
  endtask

  task automatic test_duty_change();
    logic [CNT_W-1:0] want_p[5];
    logic [CNT_W-1:0] want_h[5];
    logic [CNT_W-1:0] seen_h[$];
    want_p = '{40, 40, 40, 16, 16};
    want_h = '{10, 10, 10, 4, 4};
    do_reset();
    gen_wave(40, 10, 3); gen_wave(16, 4, 3); gen_low(6);
    seen_p.delete();
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL duty i=%0d %s", i, obs());
      end
      if (period_valid) begin seen_p.push_back(period); seen_h.push_back(high_time); end
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (seen_p.size() != 5) begin
      n_fail++; $display("FAIL duty_pulses got %0d want 5", seen_p.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (seen_p[k] !== want_p[k] || seen_h[k] !== want_h[k]) begin
          n_fail++;
          $display("FAIL duty_seq k=%0d got p=%0d h=%0d want p=%0d h=%0d",
                   k, seen_p[k], seen_h[k], want_p[k], want_h[k]);
        end
      end
    end
  endtask

  task automatic test_hold_high();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    sig_in  = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int j = 0; j < 10; j++) wq.push_back(1'b1);
    gen_low(10); gen_wave(20, 10, 2); gen_low(6);
    nv = 0; first_v = -1; seen_p.delete();
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL hold_high i=%0d %s", i, obs());
      end
      if (period_valid) begin nv++; seen_p.push_back(period); if (first_v < 0) first_v = i; end
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (nv != 2 || first_v != 23 || seen_p[0] !== 21) begin
      n_fail++; $display("FAIL hold_high_arm got nv=%0d at=%0d p0=%0d want 2 23 21", nv, first_v, seen_p[0]);
    end
  endtask

  task automatic test_random();
    int rises;
    int p, h, n;
    do_reset();
    rises = 0;
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(40, 4);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(3, 1);
      gen_wave(p, h, n);
      rises += n;
    end
    gen_low(6);
    nv = 0;
    for (int i = 0; wq.size() > 0; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({period, high_time, period_valid, timeout, level_out} !==
          {exp_period, exp_high, exp_valid, exp_timeout, exp_level}) begin
        n_fail++; $display("FAIL random i=%0d %s", i, obs());
      end
      if (period_valid) nv++;
      sig_in = wq.pop_front();
    end
    n_checks++;
    if (nv != rises - 1) begin
      n_fail++; $display("FAIL random_pulses got %0d want %0d", nv, rises - 1);
    end
  endtask

  initial begin
    test_reset();
    test_square20();
    test_timeout();
    test_mid_reset();
    test_duty_change();
    test_hold_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_period_meter.md
LED_PERIOD_METER -- requirements
Module: led_period_meter

Interface
REQ-001 Parameter CNT_W, default 26: width of the period, high-time and internal counters.
REQ-002 Parameter TIMEOUT, default 50_000_000: cycles without a rising edge before timeout (1 s at 50 MHz).
REQ-003 sys_clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 sys_rst  input  1  asynchronous active-high reset.
REQ-005 sig_in  input  1  asynchronous blink/pulse signal to measure (e.g. a counter-driven LED line).
REQ-006 period  output  CNT_W  last measured rising-to-rising interval, in sys_clk cycles.
REQ-007 high_time  output  CNT_W  last measured rising-to-falling interval, in sys_clk cycles.
REQ-008 period_valid  output  1  one-cycle pulse when period updates.
REQ-009 timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.
REQ-010 level_out  output  1  synchronized copy of sig_in.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer then an edge register; an edge SHALL be detected exactly 3 sys_clk cycles after sig_in changes.
REQ-012 level_out SHALL equal the second synchronizer flop.
REQ-013 The FSM SHALL have states IDLE and MEASURE; reset state IDLE.
REQ-014 In IDLE, a detected rising edge SHALL clear cnt to 0 and enter MEASURE; no period_valid.
REQ-015 In MEASURE, cnt SHALL increment by 1 every cycle without an edge.
REQ-016 In MEASURE, on a detected rising edge: period <= cnt+1, period_valid = 1 for that cycle, cnt <= 0, timeout <= 0, stay in MEASURE.
REQ-017 In MEASURE, on a detected falling edge: high_time <= cnt+1; state unchanged.
REQ-018 A square wave of period P cycles (P >= 4) SHALL therefore yield period = P; high time H SHALL yield high_time = H.
REQ-019 When cnt+1 reaches TIMEOUT in MEASURE without a rising edge: timeout <= 1, return to IDLE, period and high_time retained.
REQ-020 timeout SHALL clear only on reset or the next period_valid.
REQ-021 cnt SHALL never wrap: TIMEOUT < 2^CNT_W is a required parameter constraint.
REQ-022 Rising and falling edges cannot coincide; only one is handled per cycle by construction.
REQ-023 The first rising edge after reset or timeout SHALL only arm measurement; the first valid period arrives at the second rising edge.

Reset
REQ-024 sys_rst SHALL asynchronously force: state IDLE, cnt 0, synchronizer and edge flops 0, period 0, high_time 0, period_valid 0, timeout 0, level_out 0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial count; no period_valid is emitted on release.
REQ-026 After release, the synchronizer SHALL treat sig_in already high as a rising edge (it starts from 0).

Structure
REQ-027 State encodings and default CNT_W/TIMEOUT SHALL live in the shared lab constants include file.
REQ-028 The synchronizer plus edge detector SHALL be a sub-module sync_edge_detect (outputs level, rise, fall), reusable for key inputs.
REQ-029 Combinational output of period_valid is forbidden; all outputs SHALL be registered.

Verification
REQ-030 Square wave, 20-cycle period, 50 % duty -> first period_valid at the second rising edge + 3 cycles; period=20, high_time=10.
REQ-031 TIMEOUT=100, single rising edge then constant low -> timeout=1 exactly 100 cycles after detection; no period_valid.
REQ-032 After REQ-031, resume a 30-cycle square wave -> timeout clears at the first period_valid, period=30.
REQ-033 Assert sys_rst for 2 cycles mid-period -> all outputs 0 immediately; the next valid period is measured cleanly from the new edges.
REQ-034 25 % duty, 40-cycle wave with period change to 16 -> period 40 then 16, high_time 10 then 4, one valid pulse per rising edge.
REQ-035 sig_in held high through reset release -> one edge detected 3 cycles after release, state MEASURE, no period_valid.
